// File: rtl/adder_pkg.sv
// Shared fixed-point constants for the registered adder.
// Optional build macro ADDER_SATURATE_EN is consumed by adder_sat_core.
package adder_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_FRAC_BITS = 10;

  // Largest positive and most negative Q-format values at the default width
  localparam logic [DEF_WIDTH-1:0] FX_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] FX_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/adder_sat_core.sv
// Combinational signed fixed-point add with overflow detect.
// Define ADDER_SATURATE_EN to clamp overflowing sums; otherwise the sum wraps.
module adder_sat_core
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] sum_raw;

  // The extra top bit carries the true sign. It disagrees with the WIDTH-bit
  // sign exactly when both operands share a sign that the truncated sum lost.
  always_comb begin
    sum_raw = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf     = sum_raw[WIDTH] ^ sum_raw[WIDTH-1];
  end

`ifdef ADDER_SATURATE_EN
  always_comb begin
    sum = sum_raw[WIDTH-1:0];
    if (ovf) begin
      sum = sum_raw[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    sum = sum_raw[WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/adder.sv
// Registered signed fixed-point adder, one-cycle latency, sticky overflow.
// Saturation instead of wrap is selected by the ADDER_SATURATE_EN macro.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  input  logic             in_valid,
  output logic             out_valid,
  output logic             ovf_sticky
);

  // The binary point never moves in an add; FRAC_BITS only has to be a legal Q split.
  if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_frac_bits
  end

  logic [WIDTH-1:0] core_sum;
  logic             core_ovf;

  adder_sat_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (A),
    .b   (B),
    .sum (core_sum),
    .ovf (core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result        <= '0;
      overflow_flag <= 1'b0;
      out_valid     <= 1'b0;
      ovf_sticky    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result        <= core_sum;
        overflow_flag <= core_ovf;
        if (core_ovf) begin
          ovf_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corner cases plus random traffic
// against an integer-arithmetic reference model.
module tb_adder;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        in_valid = 1'b0;
  logic [15:0] result;
  logic        overflow_flag;
  logic        out_valid;
  logic        ovf_sticky;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [15:0] exp_result = '0;
  logic        exp_ovf = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_sticky = 1'b0;

  adder #(
    .WIDTH     (16),
    .FRAC_BITS (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .result        (result),
    .overflow_flag (overflow_flag),
    .in_valid      (in_valid),
    .out_valid     (out_valid),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum, then wrap or clamp to the 16-bit range
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int          s;
    logic [31:0] s_bits;
    logic        o;
    logic [15:0] r;
    s      = int'($signed(a)) + int'($signed(b));
    s_bits = s;
    o      = (s > 32767) || (s < -32768);
    r      = s_bits[15:0];
`ifdef ADDER_SATURATE_EN
    if (o) r = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {o, r};
  endfunction

  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      input logic v, input logic r);
    logic [16:0] m;
    A = a; B = b; in_valid = v; rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_result = '0; exp_ovf = 1'b0; exp_valid = 1'b0; exp_sticky = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        m          = ref_add(a, b);
        exp_result = m[15:0];
        exp_ovf    = m[16];
        exp_sticky = exp_sticky | m[16];
      end
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic test_reset();
    step(16'h7FFF, 16'h0001, 1'b1, 1'b1);
    n_compared++;
    if ({result, overflow_flag, out_valid, ovf_sticky} !== 19'h0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_state: got %h/%b/%b/%b want 0000/0/0/0",
               result, overflow_flag, out_valid, ovf_sticky);
    end
    step(16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_corners();
    logic [15:0] ta [6] = '{16'h0400, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFC00, 16'h8000};
    logic [15:0] tb [6] = '{16'h0400, 16'h0001, 16'hFFFF, 16'h8000, 16'h0400, 16'h8000};
`ifdef ADDER_SATURATE_EN
    logic [15:0] tr [6] = '{16'h0800, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000};
`else
    logic [15:0] tr [6] = '{16'h0800, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0000};
`endif
    logic        to [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ts [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(ta[i], tb[i], 1'b1, 1'b0);
      n_compared++;
      if ({result, overflow_flag, out_valid, ovf_sticky} !== {tr[i], to[i], 1'b1, ts[i]}) begin
        n_mismatch++;
        $display("[TB] FAIL corner_%0d (%h+%h): got %h/%b/%b/%b want %h/%b/1/%b",
                 i, ta[i], tb[i], result, overflow_flag, out_valid, ovf_sticky,
                 tr[i], to[i], ts[i]);
      end
    end
  endtask

  task automatic test_random();
    step(16'h0000, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(pick_operand(), pick_operand(), 1'($urandom_range(0, 3) != 0), 1'b0);
      n_compared++;
      if ({result, overflow_flag, out_valid, ovf_sticky} !==
          {exp_result, exp_ovf, exp_valid, exp_sticky}) begin
        n_mismatch++;
        $display("[TB] FAIL random_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 result, overflow_flag, out_valid, ovf_sticky,
                 exp_result, exp_ovf, exp_valid, exp_sticky);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] held;
    logic        held_ovf;
    for (int i = 0; i < 8; i++) begin
      step(16'($urandom()), 16'($urandom()), 1'b1, 1'b0);
      n_compared++;
      if ({result, overflow_flag, out_valid} !== {exp_result, exp_ovf, 1'b1}) begin
        n_mismatch++;
        $display("[TB] FAIL b2b_%0d: got %h/%b/%b want %h/%b/1", i,
                 result, overflow_flag, out_valid, exp_result, exp_ovf);
      end
    end
    held     = exp_result;
    held_ovf = exp_ovf;
    for (int i = 0; i < 2; i++) begin
      step(16'($urandom()), 16'($urandom()), 1'b0, 1'b0);
      n_compared++;
      if ({result, overflow_flag, out_valid} !== {held, held_ovf, 1'b0}) begin
        n_mismatch++;
        $display("[TB] FAIL hold_%0d: got %h/%b/%b want %h/%b/0", i,
                 result, overflow_flag, out_valid, held, held_ovf);
      end
    end
  endtask

  task automatic test_reset_after_overflow();
    step(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    step(16'h0001, 16'h0001, 1'b1, 1'b0);
    n_compared++;
    if ({overflow_flag, ovf_sticky} !== 2'b01) begin
      n_mismatch++;
      $display("[TB] FAIL sticky_hold: got ovf=%b sticky=%b want ovf=0 sticky=1",
               overflow_flag, ovf_sticky);
    end
    step(16'h8000, 16'h8000, 1'b1, 1'b1);
    n_compared++;
    if ({result, overflow_flag, out_valid, ovf_sticky} !== 19'h0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_after_ovf: got %h/%b/%b/%b want 0000/0/0/0",
               result, overflow_flag, out_valid, ovf_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_after_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL provide parameter FRAC_BITS, default 10, fractional bit count (signed two's-complement Q(WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port A, input, WIDTH, signed fixed-point operand.
REQ-006 SHALL have port B, input, WIDTH, signed fixed-point operand.
REQ-007 SHALL have port in_valid, input, 1, qualifies A/B this cycle.
REQ-008 SHALL have port result, output, WIDTH, registered sum.
REQ-009 SHALL have port overflow_flag, output, 1, registered signed-overflow indicator for result.
REQ-010 SHALL have port out_valid, output, 1, result/overflow_flag valid this cycle.
REQ-011 SHALL have port ovf_sticky, output, 1, set by any overflow since reset.
REQ-012 SHALL order ports: clk, rst, A, B, result, overflow_flag, in_valid, out_valid, ovf_sticky.

Function
REQ-013 SHALL compute raw sum A+B in WIDTH+1 bits, sign-extended operands; binary point unchanged (no scaling, no rounding).
REQ-014 SHALL detect overflow when A and B have equal sign bits and the WIDTH-bit sum sign differs.
REQ-015 SHALL have one-cycle latency: inputs sampled at edge N with in_valid=1 appear on result/overflow_flag with out_valid=1 after edge N.
REQ-016 SHALL hold result and overflow_flag unchanged when in_valid=0; out_valid SHALL drop to 0 after that edge.
REQ-017 SHALL set ovf_sticky on any accepted overflow; it SHALL clear only on rst.
REQ-018 SHALL accept a new operand pair every cycle (no backpressure, no stall).
REQ-019 SHALL treat 0x8000+0x8000 as negative overflow; 0x7FFF+0x8000 SHALL give 0xFFFF with no overflow.

Reset
REQ-020 SHALL drive result=0, overflow_flag=0, out_valid=0, ovf_sticky=0 on any edge with rst=1.
REQ-021 SHALL give rst priority over in_valid; an operand pair presented with rst=1 SHALL be discarded.

Configuration
REQ-022 SHALL honor macro ADDER_SATURATE_EN: when defined, positive overflow yields max (0x7FFF at WIDTH=16), negative overflow yields min (0x8000).
REQ-023 SHALL, without ADDER_SATURATE_EN, output the wrapped WIDTH-bit sum; overflow_flag and ovf_sticky SHALL behave identically in both builds.

Structure
REQ-024 SHALL place WIDTH/FRAC_BITS defaults and MAX/MIN fixed-point constants in shared package adder_pkg.
REQ-025 SHALL implement combinational sum, overflow detect and saturation in sub-module adder_sat_core; top level holds only registers and valid logic.

Verification
REQ-026 SHALL check 0x0400+0x0400 (1.0+1.0) -> result 0x0800, overflow_flag 0, out_valid 1 one cycle later.
REQ-027 SHALL check 0x7FFF+0x0001 -> overflow_flag 1; result 0x7FFF with ADDER_SATURATE_EN, 0x8000 without; ovf_sticky 1.
REQ-028 SHALL check 0x8000+0xFFFF -> overflow_flag 1; result 0x8000 saturated, 0x7FFF wrapped.
REQ-029 SHALL check 0x7FFF+0x8000 -> 0xFFFF, overflow_flag 0; 0xFC00+0x0400 (-1.0+1.0) -> 0x0000, overflow_flag 0.
REQ-030 SHALL check back-to-back valid pairs each cycle, then in_valid=0 -> outputs held, out_valid 0.
REQ-031 SHALL check rst asserted after an overflow -> result 0, overflow_flag 0, out_valid 0, ovf_sticky 0 next edge.
